// File: rtl/com_timer_ctrl.sv
// Programmable periodic tick timer with repeat count and start/pause/stop control.
// Optional prescaler enabled by defining COM_TIMER_PRESCALE_EN.
module com_timer_ctrl #(
    parameter int unsigned C_CNT_W = 32,
    parameter int unsigned C_REP_W = 16
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic               I_cfgVld,
    output logic               O_cfgRdy,
    input  logic [C_CNT_W-1:0] I_cfgPeriod,
    input  logic [C_REP_W-1:0] I_cfgRepeat,
`ifdef COM_TIMER_PRESCALE_EN
    input  logic [7:0]         I_cfgPrescale,
`endif
    input  logic               I_start,
    input  logic               I_pause,
    input  logic               I_stop,
    output logic               O_tick,
    output logic               O_done,
    output logic               O_busy,
    output logic [1:0]         O_state,
    output logic [C_REP_W-1:0] O_tickCnt
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [C_CNT_W-1:0] CntOne = C_CNT_W'(1);
    localparam logic [C_REP_W-1:0] RepOne = C_REP_W'(1);

    state_e             state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [C_CNT_W-1:0] period_q, period_d;
    logic [C_REP_W-1:0] repeat_q, repeat_d;
    logic [C_REP_W-1:0] tick_cnt_q, tick_cnt_d;
    logic               tick_q, tick_d;
    logic               done_q, done_d;
    logic               cfg_rdy;
    logic               step_en;
    logic               wrap;
    logic               last;

`ifdef COM_TIMER_PRESCALE_EN
    logic [7:0] ps_q, ps_d;
    logic [7:0] ps_cfg_q, ps_cfg_d;
    assign step_en = (ps_q == ps_cfg_q);
`else
    assign step_en = 1'b1;
`endif

    assign cfg_rdy = (state_q == StIdle) || (state_q == StDone);
    // period_q is never 0, so period_q - 1 cannot underflow and the max period is safe.
    assign wrap    = (cnt_q == (period_q - CntOne));
    assign last    = (repeat_q != '0) && (tick_cnt_q == (repeat_q - RepOne));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        repeat_d   = repeat_q;
        tick_cnt_d = tick_cnt_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
`ifdef COM_TIMER_PRESCALE_EN
        ps_d       = ps_q;
        ps_cfg_d   = ps_cfg_q;
`endif

        if (cfg_rdy && I_cfgVld) begin
            period_d = (I_cfgPeriod == '0) ? CntOne : I_cfgPeriod;
            repeat_d = I_cfgRepeat;
`ifdef COM_TIMER_PRESCALE_EN
            ps_cfg_d = I_cfgPrescale;
`endif
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (I_start) begin
                    state_d    = StRun;
                    cnt_d      = '0;
                    tick_cnt_d = '0;
`ifdef COM_TIMER_PRESCALE_EN
                    ps_d       = '0;
`endif
                end
            end
            StRun: begin
`ifdef COM_TIMER_PRESCALE_EN
                ps_d = step_en ? 8'd0 : ps_q + 8'd1;
`endif
                if (step_en) begin
                    if (wrap) begin
                        cnt_d      = '0;
                        tick_d     = 1'b1;
                        tick_cnt_d = tick_cnt_q + RepOne;
                        if (last) begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                // The pause cycle still performs its normal update; the freeze starts after it.
                if (I_pause && !I_start && !(step_en && wrap && last)) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (I_start) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        if (I_stop) begin
            state_d    = StIdle;
            cnt_d      = '0;
            tick_cnt_d = '0;
            tick_d     = 1'b0;
            done_d     = 1'b0;
`ifdef COM_TIMER_PRESCALE_EN
            ps_d       = '0;
`endif
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            period_q   <= CntOne;
            repeat_q   <= '0;
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef COM_TIMER_PRESCALE_EN
            ps_q       <= '0;
            ps_cfg_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            repeat_q   <= repeat_d;
            tick_cnt_q <= tick_cnt_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
`ifdef COM_TIMER_PRESCALE_EN
            ps_q       <= ps_d;
            ps_cfg_q   <= ps_cfg_d;
`endif
        end
    end

    assign O_cfgRdy  = cfg_rdy;
    assign O_tick    = tick_q;
    assign O_done    = done_q;
    assign O_busy    = (state_q == StRun) || (state_q == StPause);
    assign O_state   = state_q;
    assign O_tickCnt = tick_cnt_q;

endmodule

// File: doc/com_timer_ctrl.md
Name: com_timer_ctrl

Overview:
- Programmable timer controller that sequences a periodic tick counter.
- Accepts a configuration of period and repeat count, then runs start/pause/stop sequences.
- Emits one-cycle ticks and a completion pulse.
- Sits between the control/register layer and any logic that needs periodic strobes (frame timers, test-pattern pacing).

Parameters:
- C_CNT_W, 32: width of the period register and the internal counter.
- C_REP_W, 16: width of the repeat-count register.

Ports:
- I_clk  in  1  clock.
- I_rst  in  1  synchronous, active-high reset.
- I_cfgVld  in  1  configuration write strobe.
- O_cfgRdy  out  1  config accepted this cycle if I_cfgVld; high in IDLE and DONE.
- I_cfgPeriod  in  C_CNT_W  tick period in counter cycles; 0 is treated as 1.
- I_cfgRepeat  in  C_REP_W  number of ticks before DONE; 0 means run forever.
- I_start  in  1  start from IDLE/DONE, or resume from PAUSE.
- I_pause  in  1  freeze the counter while in RUN.
- I_stop  in  1  abort to IDLE from any state.
- O_tick  out  1  one-cycle periodic strobe.
- O_done  out  1  one-cycle pulse, coincident with the final tick.
- O_busy  out  1  high in RUN or PAUSE.
- O_state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- O_tickCnt  out  C_REP_W  ticks issued since the last start; wraps in infinite mode.

Behaviour:
- Reset values: state IDLE; all outputs 0 except O_cfgRdy=1; counter 0; period register 1; repeat register 0.
- Config handling:
  - When O_cfgRdy & I_cfgVld, capture period (0 stored as 1) and repeat count on the clock edge.
  - Config strobes are ignored in RUN and PAUSE.
- Command priority: I_stop > I_start > I_pause.
- IDLE / DONE:
  - I_start moves to RUN and clears the counter and O_tickCnt.
  - If I_cfgVld and I_start are high in the same cycle, the new config is used.
- RUN:
  - Counter increments each cycle.
  - When counter+1 == period: counter goes to 0, O_tick=1 next cycle, and O_tickCnt increments.
  - First tick is high exactly P cycles after the start edge. P=1 gives O_tick high every cycle.
  - I_pause moves to PAUSE and holds the counter. A tick due in that same cycle is still issued.
- PAUSE:
  - Counter is frozen and no ticks are issued.
  - I_start returns to RUN and resumes from the held count.
  - I_pause has no effect.
- Completion:
  - In RUN with repeat R≠0, the R-th tick asserts O_tick and O_done together and moves to DONE.
  - In DONE, O_busy=0 and O_tickCnt holds R.
- I_stop:
  - Moves to IDLE, counter to 0, O_tickCnt to 0.
  - A tick due in that same cycle is suppressed (no O_tick, no O_done).
- Registered outputs: all outputs are registered, with no combinational path from inputs to outputs except O_cfgRdy, which decodes the state.
- Reset mid-operation: I_rst overrides every input and returns all reset values on the next edge.
- Counter arithmetic: modulo 2^C_CNT_W. Period 2^C_CNT_W−1 must still tick correctly, with no overflow compare bug.

Optional Feature:
- Macro: COM_TIMER_PRESCALE_EN.
- Defined:
  - Adds input I_cfgPrescale (width 8), captured with the rest of the config.
  - A prescale counter generates an enable every (I_cfgPrescale+1) cycles. The main counter advances only on that enable, so the tick period is P×(PS+1) cycles.
  - The prescale counter clears on start and stop, and holds in PAUSE.
- Undefined: no I_cfgPrescale port; the counter advances every cycle (equivalent to PS=0).

Test Plan:
- Reset check: after reset, O_state=0, O_cfgRdy=1, O_tick=0, O_busy=0.
- Basic run: cfg P=4, R=3, start at cycle 0 → O_tick high at cycles 4, 8, 12; O_done at 12; O_state=3; O_tickCnt=3; no further ticks.
- Pause/resume: cfg P=10, R=0, start; pause at cycle 6 for 5 cycles, then start → first tick at cycle 15; subsequent ticks every 10 cycles.
- Stop collision: cfg P=5, stop asserted in the cycle the first tick is due → no O_tick; O_state=0; O_tickCnt=0.
- Config rules:
  - cfgVld with P=7 during RUN → ignored, ticks stay at the original period.
  - cfgVld P=0 with start in IDLE → O_tick every cycle.
- Prescale (macro defined): P=3, PS=1, R=2 → ticks at cycles 6 and 12; O_done at 12.
